// File: rtl/gprs_wb_arbiter_pkg.sv
// Shared types and default sizing for the GPR write-back arbiter and its scoreboard.
package gprs_wb_arbiter_pkg;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    localparam int unsigned GPRS_WIDTH     = 32;
    localparam int unsigned GPRS_REGISTERS = 32;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gprs_scoreboard.sv
// Pending-write vector: set on issue, cleared on commit, with two combinational query ports.
module gprs_scoreboard
    import gprs_wb_arbiter_pkg::*;
#(
    parameter bit          zero      = 1'b0,
    parameter int unsigned registers = GPRS_REGISTERS,
    localparam int unsigned AW       = idx_width(registers)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_idx_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_idx_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o
);

    logic [registers-1:0] pending_q, pending_d;

    function automatic logic in_range(input logic [AW-1:0] idx);
        return 32'(idx) < registers;
    endfunction

    // Set is applied after clear so a newer producer wins a same-index collision.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i && in_range(clr_idx_i)) pending_d[clr_idx_i] = 1'b0;
        if (set_en_i && in_range(set_idx_i)) pending_d[set_idx_i] = 1'b1;
        if (zero) pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    assign rs1_busy_o = in_range(rs1_i) && pending_q[rs1_i];
    assign rs2_busy_o = in_range(rs2_i) && pending_q[rs2_i];

endmodule

// File: rtl/gprs_wb_arbiter.sv
// Two-requester round-robin write-back arbiter with a registered GPR write port
// and a pending-write scoreboard for hazard queries.
module gprs_wb_arbiter
    import gprs_wb_arbiter_pkg::*;
#(
    parameter bit          zero      = 1'b0,
    parameter int unsigned width     = GPRS_WIDTH,
    parameter int unsigned registers = GPRS_REGISTERS,
    localparam int unsigned AW       = idx_width(registers)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dst,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_dst,
    input  logic [width-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_dst,
    input  logic [width-1:0] req1_data,
    output logic             req1_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             write,
    output logic [AW-1:0]    dst,
    output logic [width-1:0] dst_i
);

    req_id_t          ptr_q, ptr_d;
    logic             write_q, write_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [width-1:0] data_q, data_d;
    logic             grant0, grant1, xfer;
    logic [AW-1:0]    gnt_dst;
    logic [width-1:0] gnt_data;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && (!req1_valid || ptr_q == REQ_ALU)) grant0 = 1'b1;
            else if (req1_valid)                                 grant1 = 1'b1;
        end
        xfer     = grant0 | grant1;
        gnt_dst  = grant1 ? req1_dst  : req0_dst;
        gnt_data = grant1 ? req1_data : req0_data;

        ptr_d = ptr_q;
        if (grant0)      ptr_d = REQ_LSU;
        else if (grant1) ptr_d = REQ_ALU;

        write_d = xfer && !(zero && gnt_dst == '0);
        dst_d   = xfer ? gnt_dst  : dst_q;
        data_d  = xfer ? gnt_data : data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= REQ_ALU;
            write_q <= 1'b0;
            dst_q   <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            write_q <= write_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
        end
    end

    // Masking with reset keeps an accepted write from committing at a reset edge.
    assign write      = write_q && !reset;
    assign dst        = dst_q;
    assign dst_i      = data_q;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    gprs_scoreboard #(
        .zero      (zero),
        .registers (registers)
    ) u_scoreboard (
        .clock_i    (clock),
        .reset_i    (reset),
        .set_en_i   (issue_valid && !reset),
        .set_idx_i  (issue_dst),
        .clr_en_i   (write),
        .clr_idx_i  (dst_q),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy)
    );

endmodule

// File: tb/tb_gprs_wb_arbiter.sv
// Self-checking bench for gprs_wb_arbiter (zero=1) against a cycle-level reference model.
module tb_gprs_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_dst, req1_dst;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        write;
    logic [4:0]  dst;
    logic [31:0] dst_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_pend[32];
    int          m_ptr;
    bit          m_write;
    logic [4:0]  m_dst;
    logic [31:0] m_data;
    logic [31:0] m_rf[32];

    // Register file fed by the DUT's write port
    logic [31:0] gpr[32];

    always #5 clock = ~clock;

    gprs_wb_arbiter #(
        .zero      (1'b1),
        .width     (32),
        .registers (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .req0_valid  (req0_valid),
        .req0_dst    (req0_dst),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_dst    (req1_dst),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .write       (write),
        .dst         (dst),
        .dst_i       (dst_i)
    );

    always @(posedge clock) if (write) gpr[dst] <= dst_i;

    // Which requester the rules say wins this cycle (-1 = none).
    function automatic int exp_grant();
        if (reset) return -1;
        if (req0_valid && req1_valid) return m_ptr;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic tick();
        int g;
        bit np[32];
        int nptr;
        bit nw;
        logic [4:0] nd;
        logic [31:0] ndata;
        g = exp_grant();
        np = m_pend; nptr = m_ptr; nw = 1'b0; nd = m_dst; ndata = m_data;
        if (reset) begin
            foreach (np[i]) np[i] = 1'b0;
            nptr = 0; nd = '0; ndata = '0;
        end else begin
            if (m_write) begin
                np[m_dst] = 1'b0;
                m_rf[m_dst] = m_data;
            end
            if (issue_valid && issue_dst != 0) np[issue_dst] = 1'b1;
            if (g >= 0) begin
                nd    = (g == 0) ? req0_dst  : req1_dst;
                ndata = (g == 0) ? req0_data : req1_data;
                nw    = (nd != 0);
                nptr  = 1 - g;
            end
        end
        @(posedge clock);
        #1;
        m_pend = np; m_ptr = nptr; m_write = nw; m_dst = nd; m_data = ndata;
    endtask

    task automatic idle();
        issue_valid = 0; issue_dst = 0;
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        req0_dst = 0; req1_dst = 0; req0_data = 0; req1_data = 0; rs1 = 0; rs2 = 0;
        tick(); tick();
        req0_valid = 1; req1_valid = 1; req0_dst = 2; req1_dst = 3;
        issue_valid = 1; issue_dst = 4; rs1 = 4; rs2 = 2;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0: got %b exp 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready1: got %b exp 0", req1_ready); end
        tick();
        n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b exp 0", write); end
        n_cmp++; if (dst !== 5'd0 || dst_i !== 32'd0) begin n_err++; $display("FAIL reset_out: got dst=%0d data=%h exp 0/0", dst, dst_i); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", rs1_busy); end
        reset = 0; idle();
    endtask

    task automatic test_single();
        req0_valid = 1; req0_dst = 5; req0_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready: got %b%b exp 10", req0_ready, req1_ready); end
        tick(); idle();
        n_cmp++; if (write !== 1'b1 || dst !== 5'd5 || dst_i !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL single_out: got w=%b dst=%0d data=%h exp 1/5/deadbeef", write, dst, dst_i); end
        tick();
        n_cmp++; if (write !== 1'b0 || dst !== 5'd5 || dst_i !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL single_hold: got w=%b dst=%0d data=%h exp 0/5/deadbeef", write, dst, dst_i); end
    endtask

    task automatic test_contention();
        int exp_seq[4] = '{0, 1, 0, 1};
        // Last grant went to requester 0; one lone requester-1 transfer points back at 0.
        req1_valid = 1; req1_dst = 6; req1_data = 32'h66;
        tick();
        req0_valid = 1; req0_dst = 3; req0_data = 32'hA0;
        req1_valid = 1; req1_dst = 4; req1_data = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (req0_ready !== (exp_seq[i] == 0) || req1_ready !== (exp_seq[i] == 1))
                begin n_err++; $display("FAIL contention_grant%0d: got %b%b exp grant %0d", i, req0_ready, req1_ready, exp_seq[i]); end
            tick();
            n_cmp++; if (write !== 1'b1 || dst !== ((exp_seq[i] == 0) ? 5'd3 : 5'd4))
                begin n_err++; $display("FAIL contention_write%0d: got w=%b dst=%0d exp 1/%0d", i, write, dst, exp_seq[i] + 3); end
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_dst = 7; rs1 = 7;
        tick(); idle();
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_set: got %b exp 1", rs1_busy); end
        req0_valid = 1; req0_dst = 7; req0_data = 32'h77;
        tick(); idle();
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_before_commit: got %b exp 1", rs1_busy); end
        tick();
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_cleared: got %b exp 0", rs1_busy); end
    endtask

    task automatic test_collision();
        issue_valid = 1; issue_dst = 9; rs2 = 9;
        tick(); idle();
        req0_valid = 1; req0_dst = 9; req0_data = 32'h99;
        tick(); idle();
        issue_valid = 1; issue_dst = 9;
        tick(); idle();
        n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL collision_set_wins: got %b exp 1", rs2_busy); end
        tick();
        n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL collision_stays: got %b exp 1", rs2_busy); end
    endtask

    task automatic test_zero();
        issue_valid = 1; issue_dst = 0; rs2 = 0;
        tick(); idle();
        n_cmp++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b exp 0", rs2_busy); end
        req0_valid = 1; req0_dst = 0; req0_data = 32'h1234;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b exp 1", req0_ready); end
        tick(); idle();
        n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL zero_write: got %b exp 0", write); end
        tick();
        n_cmp++; if (gpr[0] !== 32'd0) begin n_err++; $display("FAIL zero_gpr0: got %h exp 0", gpr[0]); end
    endtask

    task automatic test_reset_midflight();
        req1_valid = 1; req1_dst = 11; req1_data = 32'hBAD0BAD0;
        tick(); idle();
        reset = 1;
        #1;
        n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL midreset_write: got %b exp 0", write); end
        tick();
        reset = 0; rs1 = 9; rs2 = 7;
        #1;
        n_cmp++; if (write !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            begin n_err++; $display("FAIL midreset_state: got w=%b b1=%b b2=%b exp 0/0/0", write, rs1_busy, rs2_busy); end
        n_cmp++; if (gpr[11] !== m_rf[11]) begin n_err++; $display("FAIL midreset_discard: got %h exp %h", gpr[11], m_rf[11]); end
        req0_valid = 1; req0_dst = 1; req0_data = 32'h1;
        req1_valid = 1; req1_dst = 2; req1_data = 32'h2;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin n_err++; $display("FAIL midreset_ptr: got %b%b exp 10", req0_ready, req1_ready); end
        tick(); idle();
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(63) == 0);
            issue_valid = $urandom_range(1); issue_dst = 5'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            #1;
            g = exp_grant();
            n_cmp++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1))
                begin n_err++; $display("FAIL rnd_grant c=%0d: got %b%b exp grant %0d", c, req0_ready, req1_ready, g); end
            n_cmp++; if (rs1_busy !== m_pend[rs1] || rs2_busy !== m_pend[rs2])
                begin n_err++; $display("FAIL rnd_busy c=%0d: got %b%b exp %b%b", c, rs1_busy, rs2_busy, m_pend[rs1], m_pend[rs2]); end
            n_cmp++; if (write !== (m_write && !reset) || dst !== m_dst || dst_i !== m_data)
                begin n_err++; $display("FAIL rnd_out c=%0d: got w=%b dst=%0d data=%h exp %b/%0d/%h", c, write, dst, dst_i, m_write && !reset, m_dst, m_data); end
            tick();
            // A requester keeps its request until it has been granted.
            if (!req0_valid || g == 0) begin
                req0_valid = $urandom_range(1); req0_dst = 5'($urandom); req0_data = $urandom;
            end
            if (!req1_valid || g == 1) begin
                req1_valid = $urandom_range(1); req1_dst = 5'($urandom); req1_data = $urandom;
            end
        end
        reset = 0; idle();
        tick(); tick();
        for (int r = 0; r < 32; r++) begin
            n_cmp++; if (gpr[r] !== m_rf[r]) begin n_err++; $display("FAIL rnd_gpr%0d: got %h exp %h", r, gpr[r], m_rf[r]); end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            gpr[r] = '0; m_rf[r] = '0; m_pend[r] = 1'b0;
        end
        m_ptr = 0; m_write = 0; m_dst = '0; m_data = '0;
        test_reset();
        test_single();
        test_contention();
        test_scoreboard();
        test_collision();
        test_zero();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gprs_wb_arbiter.md
GPRS_WB_ARBITER -- requirements
Module: gprs_wb_arbiter

Interface
REQ-001 Parameter zero, default 0: when 1, register 0 is hard-wired zero; writes to it are accepted but never committed.
REQ-002 Parameter width, default 32: data width of register writes.
REQ-003 Parameter registers, default 32: register count. Index width AW = $clog2(registers).
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 issue_valid  in  1  an instruction with destination issue_dst has issued; mark issue_dst pending.
REQ-007 issue_dst  in  AW  destination index being issued.
REQ-008 req0_valid / req1_valid  in  1  write-back request from requester 0 (ALU) / requester 1 (load unit).
REQ-009 req0_dst / req1_dst  in  AW  write-back destination index.
REQ-010 req0_data / req1_data  in  width  write-back data.
REQ-011 req0_ready / req1_ready  out  1  request accepted this cycle (combinational grant).
REQ-012 rs1 / rs2  in  AW  source indices being queried.
REQ-013 rs1_busy / rs2_busy  out  1  queried register has a pending, uncommitted write.
REQ-014 write  out  1  register-file write enable (drives GPRs write).
REQ-015 dst  out  AW  register-file destination index (drives GPRs dst).
REQ-016 dst_i  out  width  register-file write data (drives GPRs dst_i).

Function
REQ-017 A request transfers when valid and ready are both 1 at a rising edge; at most one request transfers per cycle.
REQ-018 Only one requester valid: that requester is granted (ready=1) in the same cycle.
REQ-019 Both valid: grant the requester indicated by the round-robin pointer; the other sees ready=0 and holds its request.
REQ-020 After a grant to requester k, the pointer moves to the other requester; with no grant, the pointer holds.
REQ-021 A requester's valid, dst and data stay stable until it sees ready; the block does not check this.
REQ-022 Output stage is registered. One cycle after a transfer: write=1, dst=granted dst, dst_i=granted data.
REQ-023 In a cycle with no transfer, the next write=0; dst and dst_i hold their previous values.
REQ-024 When zero=1 and the granted dst is 0, the transfer completes but the next write=0.
REQ-025 Scoreboard: a registers-bit pending vector. issue_valid sets bit issue_dst at the edge.
REQ-026 When zero=1, issue of dst 0 sets nothing, and bit 0 always reads 0.
REQ-027 The pending bit for dst is cleared at the edge where the output stage has write=1. This is the same edge at which GPRs captures the data.
REQ-028 If a set and a clear hit the same index at the same edge, the set wins (a newer producer exists).
REQ-029 rs1_busy = pending[rs1] and rs2_busy = pending[rs2], combinationally from the registered vector, with no same-cycle bypass.
REQ-030 Issue to an already-pending index leaves it pending. Write-back to a non-pending index commits normally.
REQ-031 Throughput: one write per cycle sustained, with back-to-back transfers and no bubble.

Reset
REQ-032 While reset=1: req0_ready=0 and req1_ready=0, and no transfer, set or clear occurs.
REQ-033 At a reset edge: pending vector cleared to all 0, pointer set to requester 0, write=0, dst=0, dst_i=0.
REQ-034 Reset asserted mid-operation discards any accepted-but-uncommitted write; that write is never committed.

Structure
REQ-035 A shared package holds the requester-ID enum (REQ_ALU=0, REQ_LSU=1) and the default parameter constants (width 32, registers 32).
REQ-036 One sub-module, gprs_scoreboard, holds the pending vector with its set, clear and two query ports.
REQ-037 The arbiter, pointer and output register stay in the top module.
REQ-038 The top module connects directly to the GPRs write, dst and dst_i ports with no glue logic.

Verification
REQ-039 Single requester: req0 valid, dst=5, data=0xDEADBEEF → req0_ready=1 the same cycle; next cycle write=1, dst=5, dst_i=0xDEADBEEF.
REQ-040 Contention: both valid for 4 cycles (req0 dst=3, req1 dst=4), pointer at 0 → grants go 0,1,0,1; write is 1 every cycle.
REQ-041 Scoreboard: issue dst=7; rs1=7 → rs1_busy=1 next cycle. Write-back dst=7 accepted → rs1_busy stays 1 one more cycle, then drops to 0 after the commit edge.
REQ-042 Set/clear collision: issue dst=9 at the same edge the output stage commits dst=9 → pending[9]=1 afterwards.
REQ-043 zero=1: issue dst=0 → rs2_busy=0 for rs2=0. Write-back dst=0, data=0x1234 → ready=1, next write=0, and GPRs reads 0 at register 0.
REQ-044 Reset mid-flight: transfer accepted, reset asserted the next cycle → write=0, all busy=0, and the pointer selects requester 0 on the first contention after reset.
